input_port_controller: RTL and testbench
========================================

# input_port_controller

Memory-mapped input peripheral for the single-cycle MIPS core, the receive-side counterpart of the output module. It captures the 16 board switches on each debounced button press into a 4-entry FIFO. The processor reads the entries through a data address, and a status word through a second address. The block sits beside the data memory: its read data merges into the MemToReg path, and its stall request is ORed into the PC hold logic.

## Interface
- DATA_ADDR, 32'd1020: load from this address pops one FIFO entry.
- STATUS_ADDR, 32'd1021: load from this address returns the status word.
- DEPTH, 4: FIFO entries; must be a power of two, max 8.
- SIGN_EXT, 1: 1 sign-extends the 16-bit entry to 32 bits on read; 0 zero-extends.
- clock  in  1  processor clock (Temporizador output).
- rst  in  1  reset; synchronous, active-high.
- switches  in  16  board switch levels; asynchronous.
- button  in  1  debounced button level (DeBounce_v output); asynchronous to clock.
- adress  in  32  ALU result (load address).
- MemRead  in  1  processor is executing a load this cycle.
- datain  out  32  read data toward MuxMem; combinational.
- wait_in  out  1  stall request; combinational.
- count  out  4  current FIFO occupancy, 0..DEPTH; registered.
- overrun  out  1  sticky dropped-press flag; registered.

## Operation
- **Button synchronizer and edge detect**
  - button passes through flops s1 → s2 → s3.
  - press = s2 & ~s3.
  - s1/s2/s3 reset to 1, so a button held through reset produces no press until it is released and pressed again.
- **Push**
  - On press, switches is sampled at the same edge as the push, from a 2-flop-synchronized copy of the switches.
  - The 16-bit value is written at wr_ptr; wr_ptr and count increment.
- **Full**
  - A press while count==DEPTH is dropped and overrun is set to 1.
  - Exception: if a pop happens in the same cycle, the push is accepted, count stays DEPTH, and overrun is unchanged.
- **Data read** (MemRead && adress==DATA_ADDR)
  - count>0: datain = extended entry at rd_ptr; wait_in=0; rd_ptr increments and count decrements at the clock edge.
  - count==0: datain=0 and wait_in=1, with no pop. The core holds the PC and retries every cycle.
- **Status read** (MemRead && adress==STATUS_ADDR)
  - datain = {26'b0, overrun, empty, full, count[2:0]}, where bit5 is overrun.
  - Never stalls.
  - Clears overrun at the edge, unless a drop occurs in the same cycle; set wins.
- **Other addresses, or MemRead=0**: datain=0, wait_in=0, no state change.
- **Simultaneous push and pop**
  - Both take effect and count is unchanged.
  - With count==0, the registered count still forces the stall. The push lands, and the read completes in the next cycle.
- **Pointers** are PTR_W=log2(DEPTH) bits wide and wrap modulo DEPTH.
- **Reset**
  - Pointers, count and overrun go to 0; FIFO contents are don't-care.
  - Reset mid-stall drops wait_in in the next cycle.
  - Reset while pushing discards the push.

## Timing
- Reset values:
  - datain=0 and wait_in=0 (no load asserted).
  - count=0, overrun=0.
- Press latency: button rises before edge k → s1 at k, s2 at k+1, press high in cycle k+1..k+2 → push at edge k+2 → count visible after k+2.
- One press generates exactly one push, regardless of hold length.
- Data read latency: zero cycles. datain is valid in the same cycle as MemRead; the pop commits at the end of that cycle.
- Stall release: the first cycle after the push edge reads with wait_in=0.
- Minimum press spacing: 2 clocks between release and the next rise (s3 must see the low level).

## Test plan
- **Reset with button held high**: assert rst for 2 cycles with button=1, then release rst and hold 10 cycles → count=0, no push; then drop button for 3 cycles and raise it → count=1 three edges after the rise.
- **Single capture, signed**: switches=16'hFFFE, one press; load DATA_ADDR → datain=32'hFFFFFFFE, count returns 0. With SIGN_EXT=0 → 32'h0000FFFE.
- **FIFO order and wrap**: press with 1,2,3,4, pop 2, press with 5,6, pop 4 → reads 1,2,3,4,5,6 in order; count ends at 0.
- **Overrun**:
  - 5 presses (values 10..14) with no reads → count=4 and overrun=1.
  - Status read → datain=32'h2C (overrun=1, full=1, count=4); overrun=0 next cycle.
  - Data reads then return 10,11,12,13.
- **Stall**: load DATA_ADDR with count=0 for 6 cycles → wait_in=1 and datain=0 each cycle. A press with 16'h0007 is pushed at cycle 3 → the next cycle shows wait_in=0, datain=7, then count=0.
- **Full with simultaneous pop**: count=4 and a press coincide with a data read → push accepted, count stays 4, overrun stays 0.

Source files
------------

// File: rtl/input_port_controller.sv
// input_port_controller: memory-mapped switch capture peripheral for the
// single-cycle MIPS core. Each debounced button press snapshots the 16 board
// switches into a small FIFO. A load from DATA_ADDR pops the oldest entry. A load
// from STATUS_ADDR returns {overrun, empty, full, count[2:0]}.
//
// Handshake: a load to DATA_ADDR is the request (valid). wait_in is the inverse
// of ready. While the FIFO is empty, wait_in stays high and no pop occurs. The
// core holds the PC and repeats the same load. The pop commits on the first
// clock edge where the request is seen with wait_in low.
module input_port_controller #(
  parameter logic [31:0] DATA_ADDR   = 32'd1020,
  parameter logic [31:0] STATUS_ADDR = 32'd1021,
  parameter int          DEPTH       = 4,
  parameter bit          SIGN_EXT    = 1'b1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] switches,
  input  logic        button,
  input  logic [31:0] adress,
  input  logic        MemRead,
  output logic [31:0] datain,
  output logic        wait_in,
  output logic [3:0]  count,
  output logic        overrun
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  // Button synchronizer / edge detector chain (reset high: a held button is not a press)
  logic r_s1;
  logic r_s2;
  logic r_s3;
  // Two-flop synchronized copy of the switches, used as push data
  logic [15:0] r_sw1;
  logic [15:0] r_sw2;
  // FIFO storage and bookkeeping
  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [3:0]       r_count;
  logic             r_overrun;

  logic        w_press;
  logic        w_data_rd;
  logic        w_status_rd;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [15:0] w_entry;
  logic [31:0] w_entry_ext;
  logic [31:0] w_status;

  assign w_press     = r_s2 & ~r_s3;
  assign w_data_rd   = MemRead && (adress == DATA_ADDR);
  assign w_status_rd = MemRead && (adress == STATUS_ADDR);
  assign w_empty     = (r_count == 4'd0);
  assign w_full      = (r_count == DEPTH_C);
  assign w_pop       = w_data_rd && !w_empty;
  // A press into a full FIFO still lands if a pop frees a slot in the same cycle.
  assign w_push      = w_press && (!w_full || w_pop);
  assign w_drop      = w_press && w_full && !w_pop;

  assign w_entry     = r_mem[r_rd_ptr];
  assign w_entry_ext = SIGN_EXT ? {{16{w_entry[15]}}, w_entry} : {16'b0, w_entry};
  assign w_status    = {26'b0, r_overrun, w_empty, w_full, r_count[2:0]};

  // Read mux toward MuxMem and stall request; both purely combinational
  always_comb begin
    datain  = 32'b0;
    wait_in = 1'b0;
    if (w_data_rd) begin
      if (w_empty) begin
        wait_in = 1'b1;
      end else begin
        datain = w_entry_ext;
      end
    end else if (w_status_rd) begin
      datain = w_status;
    end
  end

  assign count   = r_count;
  assign overrun = r_overrun;

  // Synchronize the asynchronous button into the clock domain
  always_ff @(posedge clock) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= button;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Synchronize the switch levels; pure datapath, no reset needed
  always_ff @(posedge clock) begin
    r_sw1 <= switches;
    r_sw2 <= r_sw1;
  end

  // FIFO storage write; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= r_sw2;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards any push in flight
  always_ff @(posedge clock) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun: set by a dropped press, cleared by a status read; set wins
  always_ff @(posedge clock) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (w_status_rd) begin
      r_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_port_controller.sv
// Bench for input_port_controller: a cycle table with fixed expectations, hand
// sequences for FIFO order/overrun/full+pop/reset, then random traffic, all
// shadowed every cycle by a queue-based reference model.
module tb_input_port_controller;

  localparam logic [31:0] DATA_ADDR   = 32'd1020;
  localparam logic [31:0] STATUS_ADDR = 32'd1021;
  localparam int          DEPTH       = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        rst;
  logic [15:0] switches;
  logic        button;
  logic [31:0] adress;
  logic        MemRead;
  logic [31:0] datain, datain_z;
  logic        wait_in, wait_z;
  logic [3:0]  count, count_z;
  logic        overrun, ovr_z;

  always #5 clock = ~clock;

  input_port_controller #(.DATA_ADDR(DATA_ADDR), .STATUS_ADDR(STATUS_ADDR),
                          .DEPTH(DEPTH), .SIGN_EXT(1'b1)) dut (
    .clock(clock), .rst(rst), .switches(switches), .button(button),
    .adress(adress), .MemRead(MemRead), .datain(datain), .wait_in(wait_in),
    .count(count), .overrun(overrun)
  );

  input_port_controller #(.DATA_ADDR(DATA_ADDR), .STATUS_ADDR(STATUS_ADDR),
                          .DEPTH(DEPTH), .SIGN_EXT(1'b0)) dut_z (
    .clock(clock), .rst(rst), .switches(switches), .button(button),
    .adress(adress), .MemRead(MemRead), .datain(datain_z), .wait_in(wait_z),
    .count(count_z), .overrun(ovr_z)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending presses are derived from the button levels seen at past edges:
  // a push happens at an edge when the level two edges back was high and the
  // level three edges back was low. Push data is the switch level two edges back.
  logic [15:0] mq[$];
  bit          m_ovr;
  bit          bh[3];
  logic [15:0] swh[2];

  function automatic logic [31:0] ext(input logic [15:0] v, input bit s);
    return s ? {{16{v[15]}}, v} : {16'b0, v};
  endfunction

  task automatic model_check();
    logic [31:0] e_dat, e_dat_z;
    bit          e_wait;
    int          n;
    n       = mq.size();
    e_dat   = 32'b0;
    e_dat_z = 32'b0;
    e_wait  = 1'b0;
    if (MemRead && adress == DATA_ADDR) begin
      if (n == 0) e_wait = 1'b1;
      else begin
        e_dat   = ext(mq[0], 1'b1);
        e_dat_z = ext(mq[0], 1'b0);
      end
    end else if (MemRead && adress == STATUS_ADDR) begin
      e_dat = n * 1 + (n == DEPTH ? 8 : 0) + (n == 0 ? 16 : 0) + (m_ovr ? 32 : 0);
      if (n == 8) e_dat = e_dat - 8; // count[2:0] field only
      e_dat_z = e_dat;
    end
    check("model_datain", datain, e_dat);
    check("model_datain_zext", datain_z, e_dat_z);
    check("model_wait", {31'b0, wait_in}, {31'b0, e_wait});
    check("model_wait_zext", {31'b0, wait_z}, {31'b0, e_wait});
    check("model_count", {28'b0, count}, n);
    check("model_count_zext", {28'b0, count_z}, n);
    check("model_overrun", {31'b0, overrun}, {31'b0, m_ovr});
    check("model_overrun_zext", {31'b0, ovr_z}, {31'b0, m_ovr});
  endtask

  task automatic model_update();
    bit press, data_rd, status_rd, pop, drop;
    int n;
    press     = bh[1] && !bh[2];
    data_rd   = MemRead && adress == DATA_ADDR;
    status_rd = MemRead && adress == STATUS_ADDR;
    if (rst) begin
      mq.delete();
      m_ovr = 1'b0;
      bh[0] = 1'b1; bh[1] = 1'b1; bh[2] = 1'b1;
    end else begin
      n    = mq.size();
      pop  = data_rd && n > 0;
      drop = press && n == DEPTH && !pop;
      if (pop) void'(mq.pop_front());
      if (press && !drop) mq.push_back(swh[1]);
      if (drop) m_ovr = 1'b1;
      else if (status_rd) m_ovr = 1'b0;
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = button;
    end
    swh[1] = swh[0];
    swh[0] = switches;
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] obs_dat;
  logic        obs_wait;
  logic [3:0]  obs_cnt;
  logic        obs_ovr;

  // One clock: inputs are already stable; sample mid-cycle, then advance.
  task automatic step();
    @(negedge clock);
    model_check();
    obs_dat  = datain;
    obs_wait = wait_in;
    obs_cnt  = count;
    obs_ovr  = overrun;
    @(posedge clock);
    model_update();
    #1;
  endtask

  // op: 0 idle, 1 data load, 2 status load
  task automatic drive_op(input int op);
    case (op)
      1:       begin MemRead = 1'b1; adress = DATA_ADDR;   end
      2:       begin MemRead = 1'b1; adress = STATUS_ADDR; end
      default: begin MemRead = 1'b0; adress = 32'd0;       end
    endcase
  endtask

  // Release for two clocks, then rise; push lands at the end of the 5th cycle.
  task automatic press(input logic [15:0] v, input bit pop_at_push);
    switches = v;
    button = 1'b0; step(); step();
    button = 1'b1; step(); step();
    if (pop_at_push) drive_op(1);
    step();
    drive_op(0);
  endtask

  task automatic pop_expect(input logic [15:0] v, input string name);
    drive_op(1);
    step();
    drive_op(0);
    check(name, obs_dat, ext(v, 1'b1));
    check({name, "_wait"}, {31'b0, obs_wait}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          btn;
    logic [15:0] sw;
    int          op;
    logic [31:0] e_dat;
    bit          e_wait;
    logic [3:0]  e_cnt;
    bit          e_ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit b, logic [15:0] s, int op,
                              logic [31:0] d, bit w, logic [3:0] c, bit o);
    vec_t v;
    v.rst = r; v.btn = b; v.sw = s; v.op = op;
    v.e_dat = d; v.e_wait = w; v.e_cnt = c; v.e_ovr = o;
    tbl.push_back(v);
  endfunction

  // ---------------- main test ----------------
  initial begin
    rst = 1'b1; button = 1'b1; switches = 16'h0; MemRead = 1'b0; adress = 32'd0;
    @(posedge clock);
    model_update();
    #1;

    // Reset with button held, single signed capture, then stall released by a press.
    add(1, 1, 16'h0000, 0, 32'h0, 0, 0, 0);
    for (int i = 1; i <= 10; i++)
      add(0, 1, 16'h0000, (i == 5) ? 1 : 0, 32'h0, (i == 5), 0, 0);
    for (int i = 11; i <= 13; i++) add(0, 0, 16'hFFFE, 0, 32'h0, 0, 0, 0);
    for (int i = 14; i <= 16; i++) add(0, 1, 16'hFFFE, 0, 32'h0, 0, 0, 0);
    add(0, 1, 16'hFFFE, 0, 32'h0, 0, 1, 0);
    add(0, 0, 16'h0007, 1, 32'hFFFF_FFFE, 0, 1, 0);
    add(0, 0, 16'h0007, 0, 32'h0, 0, 0, 0);
    for (int i = 20; i <= 22; i++) add(0, 1, 16'h0007, 1, 32'h0, 1, 0, 0);
    add(0, 1, 16'h0007, 1, 32'h0000_0007, 0, 1, 0);
    for (int i = 24; i <= 25; i++) add(0, 1, 16'h0007, 1, 32'h0, 1, 0, 0);
    add(0, 0, 16'h0007, 0, 32'h0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; button = tbl[i].btn; switches = tbl[i].sw;
      drive_op(tbl[i].op);
      step();
      check($sformatf("vec%0d_datain", i), obs_dat, tbl[i].e_dat);
      check($sformatf("vec%0d_wait", i), {31'b0, obs_wait}, {31'b0, tbl[i].e_wait});
      check($sformatf("vec%0d_count", i), {28'b0, obs_cnt}, {28'b0, tbl[i].e_cnt});
      check($sformatf("vec%0d_overrun", i), {31'b0, obs_ovr}, {31'b0, tbl[i].e_ovr});
    end
    drive_op(0);

    // FIFO order and pointer wrap
    for (int v = 1; v <= 4; v++) press(16'(v), 1'b0);
    pop_expect(16'd1, "order_1");
    pop_expect(16'd2, "order_2");
    press(16'd5, 1'b0);
    press(16'd6, 1'b0);
    for (int v = 3; v <= 6; v++) pop_expect(16'(v), $sformatf("order_%0d", v));
    step();
    check("order_end_count", {28'b0, obs_cnt}, 32'd0);

    // Overrun: fifth press dropped, status read reports and clears it
    for (int v = 10; v <= 14; v++) press(16'(v), 1'b0);
    step();
    check("ovr_count", {28'b0, obs_cnt}, 32'd4);
    check("ovr_flag", {31'b0, obs_ovr}, 32'd1);
    drive_op(2);
    step();
    drive_op(0);
    check("ovr_status_word", obs_dat, 32'h0000_002C);
    step();
    check("ovr_cleared", {31'b0, obs_ovr}, 32'd0);
    for (int v = 10; v <= 13; v++) pop_expect(16'(v), $sformatf("ovr_pop_%0d", v));

    // Full with a coincident pop: push accepted, count stays at DEPTH
    for (int v = 20; v <= 23; v++) press(16'(v), 1'b0);
    press(16'd24, 1'b1);
    check("fullpop_read", obs_dat, 32'd20);
    step();
    check("fullpop_count", {28'b0, obs_cnt}, 32'd4);
    check("fullpop_ovr", {31'b0, obs_ovr}, 32'd0);
    for (int v = 21; v <= 24; v++) pop_expect(16'(v), $sformatf("fullpop_pop_%0d", v));

    // Reset at the push edge discards the push; held button gives no later press
    switches = 16'h0055;
    button = 1'b0; step(); step();
    button = 1'b1; step(); step();
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("rst_push_discarded", {28'b0, obs_cnt}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) button = ~button;
      if ($urandom_range(0, 7) == 0) switches = 16'($urandom);
      MemRead = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0, 1, 2: adress = DATA_ADDR;
        3:       adress = STATUS_ADDR;
        4:       adress = DATA_ADDR - 32'd1;
        default: adress = $urandom;
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
